uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Receive-path controller placed between the UART receiver and the CPU bus adapter.
//   Gates the receiver enable, buffers received bytes in a first-word-fall-through FIFO,
//   and presents them on a valid/ready stream. Raises sticky overflow/break flags and
//   an idle-timeout pulse so software can drain short messages without polling.
// PARAMETERS
//   PAYLOAD_BITS    8     width of one received word; matches the receiver payload width
//   FIFO_DEPTH      16    FIFO entries; power of two, 2..256; ADDR_W = log2(FIFO_DEPTH)
//   TIMEOUT_CYCLES  4000  idle cycles with FIFO non-empty before timeout_irq fires; >=2
// PORTS
//   clk           in   1              system clock
//   resetn        in   1              asynchronous active-low reset
//   ctrl_en       in   1              1 = receive enabled; 0 = stop and drain
//   flush         in   1              synchronous FIFO clear, one-cycle pulse
//   clr_flags     in   1              clears overflow_flag and break_flag
//   rx_valid      in   1              one-cycle pulse from the receiver: word complete
//   rx_data       in   PAYLOAD_BITS   received word; qualified by rx_valid
//   rx_break      in   1              break indication; qualified by rx_valid
//   rx_en         out  1              enable to the receiver (drives its uart_rx_en)
//   out_valid     out  1              FIFO head is valid
//   out_data      out  PAYLOAD_BITS   FIFO head word
//   out_ready     in   1              consumer accepts the head when out_valid=1
//   level         out  ADDR_W+1       FIFO occupancy, 0..FIFO_DEPTH
//   busy          out  1              state != ST_OFF
//   overflow_flag out  1              sticky: word dropped because FIFO was full
//   break_flag    out  1              sticky: break received
//   timeout_irq   out  1              one-cycle pulse on idle timeout
// BEHAVIOUR
//   Reset: all outputs 0, state ST_OFF, FIFO empty, pointers and counters 0.
//   FSM (registered):
//     ST_OFF   : rx_en=0; ctrl_en=1 -> ST_RUN.
//     ST_RUN   : rx_en=1; ctrl_en=0 -> ST_DRAIN.
//     ST_DRAIN : rx_en=0, pushes ignored; level==0 -> ST_OFF; ctrl_en=1 -> ST_RUN.
//   rx_en is registered: it changes the cycle after the state changes.
//   Push = rx_valid & state==ST_RUN & !rx_break & !flush.
//   Pop  = out_valid & out_ready & !flush.
//   rx_valid with rx_break=1: word not stored; break_flag set next cycle.
//   Push while full and no pop in the same cycle: word dropped; overflow_flag set.
//   Push and pop while full: both take effect; level stays FIFO_DEPTH; no overflow.
//   Push and pop while empty: the pushed word is stored; level goes 0 -> 1.
//   Latency: a word pushed in cycle N shows out_valid=1 and out_data in cycle N+1.
//   out_valid = (level!=0); out_data holds the head and is stable while out_valid & !out_ready.
//   Pointers are ADDR_W wide and wrap modulo FIFO_DEPTH; level is ADDR_W+1 wide.
//   flush: level, pointers and timeout counter go to 0 next cycle; FSM state is unchanged;
//     flush overrides a push or pop in the same cycle.
//   clr_flags clears both sticky flags. A set event in the same cycle as clr_flags wins.
//   Timeout counter: reset to 0 on push, pop, flush, or level==0.
//     Otherwise it increments and saturates at TIMEOUT_CYCLES.
//     timeout_irq pulses once, in the cycle the counter reaches TIMEOUT_CYCLES.
//     The pulse re-arms only after the counter is reset.
//   In ST_DRAIN the consumer may still pop. Asserting resetn mid-word discards all state.
// TESTING
//   Basic: ctrl_en=1; send 0x41,0x42,0x43 with out_ready=1 -> out_data 0x41,0x42,0x43
//     in order, each 1 cycle after its rx_valid; level ends at 0.
//   Overflow: out_ready=0; push 17 words -> level=16, overflow_flag=1, head=word 0;
//     then clr_flags -> overflow_flag=0.
//   Full simultaneous: at level 16, push 0x5A with out_ready=1 -> no overflow,
//     level=16, 0x5A stored at the tail.
//   Break: rx_valid with rx_break=1, rx_data=0x00 -> level unchanged, break_flag=1.
//   Timeout: one word pushed, out_ready=0 -> timeout_irq=1 exactly TIMEOUT_CYCLES
//     cycles after the push, once only; a pop resets the counter.
//   Drain/flush: 3 words buffered, ctrl_en=0 -> rx_en=0, a rx_valid is ignored,
//     3 pops -> ST_OFF, busy=0. Then flush at level 5 -> level=0, flags unchanged.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// Receive-path controller: gates the UART receiver, buffers words in a FWFT FIFO,
// and raises sticky overflow/break flags plus an idle-timeout pulse.
module uart_rx_ctrl #(
  parameter  int PAYLOAD_BITS   = 8,
  parameter  int FIFO_DEPTH     = 16,
  parameter  int TIMEOUT_CYCLES = 4000,
  localparam int ADDR_W         = $clog2(FIFO_DEPTH),
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    ctrl_en,
  input  logic                    flush,
  input  logic                    clr_flags,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  input  logic                    rx_break,
  output logic                    rx_en,
  output logic                    out_valid,
  output logic [PAYLOAD_BITS-1:0] out_data,
  input  logic                    out_ready,
  output logic [ADDR_W:0]         level,
  output logic                    busy,
  output logic                    overflow_flag,
  output logic                    break_flag,
  output logic                    timeout_irq
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t                  state_q;
  logic                    rx_en_q;
  logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]         level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic                    brk_q, brk_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    irq_q, irq_d;

  logic full, empty, push, pop, wr_en, drop;

  // Output stream handshake: a word transfers on a clock edge where out_valid and
  // out_ready are both 1; out_valid never drops and out_data never changes while
  // the head is offered but not taken (flush excepted).
  assign empty     = (level_q == '0);
  assign full      = (level_q == LEVEL_FULL);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign rx_en     = rx_en_q;
  assign busy      = (state_q != ST_OFF);

  assign overflow_flag = ovf_q;
  assign break_flag    = brk_q;
  assign timeout_irq   = irq_q;

  assign push  = rx_valid && (state_q == ST_RUN) && !rx_break && !flush;
  assign pop   = out_valid && out_ready && !flush;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OFF;
      rx_en_q <= 1'b0;
    end else begin
      rx_en_q <= (state_q == ST_RUN);
      unique case (state_q)
        ST_OFF:   if (ctrl_en) state_q <= ST_RUN;
        ST_RUN:   if (!ctrl_en) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if (ctrl_en)    state_q <= ST_RUN;
          else if (empty) state_q <= ST_OFF;
        end
        default:  state_q <= ST_OFF;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_en && !pop)      level_d = level_q + LEVEL_ONE;
      else if (!wr_en && pop) level_d = level_q - LEVEL_ONE;
    end
  end

  // Set events take priority over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    brk_d = brk_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
      brk_d = 1'b0;
    end
    if (drop)                 ovf_d = 1'b1;
    if (rx_valid && rx_break) brk_d = 1'b1;
  end

  // Idle counter saturates, so the pulse fires only on the step into CNT_MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (push || pop || flush || empty) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    irq_d = (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      brk_q    <= 1'b0;
      cnt_q    <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      brk_q    <= brk_d;
      cnt_q    <= cnt_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: queue-based scoreboard of FIFO contents,
// flag model, and directed FSM / timeout scenarios.
module tb_uart_rx_ctrl;

  localparam int PW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TO    = 40;

  logic          clk;
  logic          resetn;
  logic          ctrl_en;
  logic          flush;
  logic          clr_flags;
  logic          rx_valid;
  logic [PW-1:0] rx_data;
  logic          rx_break;
  logic          rx_en;
  logic          out_valid;
  logic [PW-1:0] out_data;
  logic          out_ready;
  logic [AW:0]   level;
  logic          busy;
  logic          overflow_flag;
  logic          break_flag;
  logic          timeout_irq;

  uart_rx_ctrl #(
    .PAYLOAD_BITS  (PW),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ctrl_en      (ctrl_en),
    .flush        (flush),
    .clr_flags    (clr_flags),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_break     (rx_break),
    .rx_en        (rx_en),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .level        (level),
    .busy         (busy),
    .overflow_flag(overflow_flag),
    .break_flag   (break_flag),
    .timeout_irq  (timeout_irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] exp_q[$];
  bit            model_run = 1'b0;
  bit            exp_ovf   = 1'b0;
  bit            exp_brk   = 1'b0;
  bit            mon_en    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: compares occupancy, flags and every popped word against the model.
  always @(negedge clk) begin
    if (mon_en && resetn) begin
      check("level", 32'(level), 32'(exp_q.size()));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("overflow_flag", 32'(overflow_flag), 32'(exp_ovf));
      check("break_flag", 32'(break_flag), 32'(exp_brk));
      if (out_valid && out_ready && !flush && exp_q.size() != 0)
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks: all start and end at posedge + 1.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_cycle(input bit vld, input logic [PW-1:0] d, input bit brk, input bit clr);
    bit will_pop, accept, drop;
    will_pop  = out_ready && (exp_q.size() != 0);
    accept    = vld && model_run && !brk && ((exp_q.size() < DEPTH) || will_pop);
    drop      = vld && model_run && !brk && !accept;
    rx_valid  = vld;
    rx_data   = d;
    rx_break  = brk;
    clr_flags = clr;
    next_cycle();
    rx_valid  = 1'b0;
    rx_break  = 1'b0;
    clr_flags = 1'b0;
    if (clr)        begin exp_ovf = 1'b0; exp_brk = 1'b0; end
    if (vld && brk) exp_brk = 1'b1;
    if (drop)       exp_ovf = 1'b1;
    if (accept)     exp_q.push_back(d);
  endtask

  // Counts edges from the last driven edge to the first timeout pulse.
  task automatic measure_timeout(input string tag);
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    for (int k = 0; k < TO + 10; k++) begin
      @(negedge clk);
      if (timeout_irq) begin
        pulses++;
        if (first < 0) first = k;
      end
      @(posedge clk);
    end
    #1;
    check({tag, "_latency"}, 32'(first), 32'(TO));
    check({tag, "_pulses"}, 32'(pulses), 32'(1));
  endtask

  initial begin
    logic [PW-1:0] first_word;
    logic [PW-1:0] d;

    resetn    = 1'b0;
    ctrl_en   = 1'b0;
    flush     = 1'b0;
    clr_flags = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    rx_break  = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level", 32'(level), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_rx_en", 32'(rx_en), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_flags", 32'({overflow_flag, break_flag, timeout_irq}), 32'(0));
    next_cycle();
    resetn = 1'b1;
    mon_en = 1'b1;

    // Enable: state moves first, rx_en follows one cycle later
    ctrl_en = 1'b1;
    next_cycle();
    model_run = 1'b1;
    @(negedge clk);
    check("en_busy", 32'(busy), 32'(1));
    check("en_rx_en_lag", 32'(rx_en), 32'(0));
    next_cycle();
    @(negedge clk);
    check("en_rx_en", 32'(rx_en), 32'(1));
    next_cycle();

    // Basic in-order stream with consumer always ready
    out_ready = 1'b1;
    rx_cycle(1'b1, 8'h41, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'h42, 1'b0, 1'b0);
    rx_cycle(1'b1, 8'h43, 1'b0, 1'b0);
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("basic_level_end", 32'(level), 32'(0));
    next_cycle();

    // Overflow: 17 words into a 16-entry FIFO
    first_word = '0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      d = PW'($urandom_range(0, 255));
      if (i == 0) first_word = d;
      rx_cycle(1'b1, d, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("ovf_level", 32'(level), 32'(DEPTH));
    check("ovf_flag", 32'(overflow_flag), 32'(1));
    check("ovf_head", 32'(out_data), 32'(first_word));
    next_cycle();
    rx_cycle(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    check("ovf_clr", 32'(overflow_flag), 32'(0));
    next_cycle();

    // Full with simultaneous push and pop
    out_ready = 1'b1;
    rx_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    out_ready = 1'b0;
    @(negedge clk);
    check("full_sim_level", 32'(level), 32'(DEPTH));
    check("full_sim_ovf", 32'(overflow_flag), 32'(0));
    next_cycle();
    out_ready = 1'b1;
    repeat (DEPTH - 1) next_cycle();
    @(negedge clk);
    check("full_sim_tail", 32'(out_data), 32'(8'h5A));
    next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("full_sim_drained", 32'(level), 32'(0));
    next_cycle();

    // Break: not stored, sticky flag, set beats clear
    rx_cycle(1'b1, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("brk_level", 32'(level), 32'(0));
    check("brk_flag", 32'(break_flag), 32'(1));
    next_cycle();
    rx_cycle(1'b0, '0, 1'b0, 1'b1);
    rx_cycle(1'b1, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    check("brk_set_wins", 32'(break_flag), 32'(1));
    next_cycle();

    // Timeout after a push, then restart after a pop
    rx_cycle(1'b1, 8'h77, 1'b0, 1'b0);
    measure_timeout("to_push");
    rx_cycle(1'b1, 8'h88, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("to_early", 32'(timeout_irq), 32'(0));
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;
    measure_timeout("to_pop");
    out_ready = 1'b1;
    next_cycle();
    out_ready = 1'b0;

    // Drain: stop receiving, ignore new words, return to OFF once empty
    for (int i = 0; i < 3; i++) rx_cycle(1'b1, PW'($urandom_range(0, 255)), 1'b0, 1'b0);
    ctrl_en = 1'b0;
    next_cycle();
    model_run = 1'b0;
    @(negedge clk);
    check("drain_busy", 32'(busy), 32'(1));
    next_cycle();
    @(negedge clk);
    check("drain_rx_en", 32'(rx_en), 32'(0));
    next_cycle();
    rx_cycle(1'b1, 8'h99, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (3) next_cycle();
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_empty", 32'(level), 32'(0));
    next_cycle();
    @(negedge clk);
    check("drain_off_busy", 32'(busy), 32'(0));
    check("drain_off_rx_en", 32'(rx_en), 32'(0));
    next_cycle();

    // Flush at level 5, overriding a simultaneous push
    ctrl_en = 1'b1;
    next_cycle();
    model_run = 1'b1;
    for (int i = 0; i < 5; i++) rx_cycle(1'b1, PW'($urandom_range(0, 255)), 1'b0, 1'b0);
    @(negedge clk);
    check("flush_pre_level", 32'(level), 32'(5));
    next_cycle();
    flush    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    next_cycle();
    flush    = 1'b0;
    rx_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_level", 32'(level), 32'(0));
    check("flush_brk_kept", 32'(break_flag), 32'(1));
    next_cycle();
    rx_cycle(1'b1, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_then_push", 32'(out_data), 32'(8'h3C));
    next_cycle();

    // Asynchronous reset mid-stream discards everything
    rx_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    mon_en = 1'b0;
    resetn = 1'b0;
    #2;
    exp_q.delete();
    check("arst_level", 32'(level), 32'(0));
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_flags", 32'({overflow_flag, break_flag}), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
